// File: rtl/bc_level_ctrl_pkg.sv
// Shared types and helpers for the box-counting level sequencer.
package bc_level_ctrl_pkg;

    // Width of every level-carrying signal (level, res_level).
    localparam int LEVEL_W = 4;

    // Sequencer states: one pass is CLR -> RUN -> REPORT, repeated per level.
    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_CLR    = 3'd1,
        ST_RUN    = 3'd2,
        ST_REPORT = 3'd3,
        ST_DONE   = 3'd4
    } state_t;

    // Last RUN cycle index for a level: a 2^L x 2^L grid is swept in 4^L cycles.
    function automatic logic [31:0] run_last_cycle(input logic [LEVEL_W-1:0] lvl);
        return (32'd1 << {lvl, 1'b0}) - 32'd1;
    endfunction

endpackage

// File: rtl/bc_box_counter.sv
// Per-level cycle counter, RUN terminal-count detect and saturating
// counter of non-zero boxes written by the square generator.
module bc_box_counter
    import bc_level_ctrl_pkg::*;
#(
    parameter int MAX_IDX = 3,
    parameter int CNT_W   = 2*MAX_IDX-1
) (
    input  logic               CLK,
    input  logic               RST_N,
    input  logic               clr,
    input  logic               run,
    input  logic [LEVEL_W-1:0] level,
    input  logic               wen,
    input  logic [7:0]         y,
    output logic [CNT_W-1:0]   count,
    output logic               last
);

    localparam int CYC_W = 2*MAX_IDX;

    logic [CYC_W-1:0] cyc_reg;
    logic [CNT_W-1:0] count_reg;

    // The final RUN cycle still samples wen; the sequencer leaves RUN after it.
    assign last  = run && (32'(cyc_reg) == run_last_cycle(level));
    assign count = count_reg;

    // Cycle and box counters: cleared per pass, advance only while running.
    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            cyc_reg   <= '0;
            count_reg <= '0;
        end else if (clr) begin
            cyc_reg   <= '0;
            count_reg <= '0;
        end else if (run) begin
            cyc_reg <= cyc_reg + CYC_W'(1);
            if (wen && (y != 8'd0) && (count_reg != '1)) begin
                count_reg <= count_reg + CNT_W'(1);
            end
        end
    end

endmodule

// File: rtl/bc_level_ctrl.sv
// Level sequencer: runs the 2x2 square generator once per box level from
// MAX_IDX down to 1, ping-ponging memory banks and reporting one
// non-zero box count per level over a valid/ready handshake.
module bc_level_ctrl
    import bc_level_ctrl_pkg::*;
#(
    parameter int MAX_IDX = 3,
    parameter int CNT_W   = 2*MAX_IDX-1
) (
    input  logic               CLK,
    input  logic               RST_N,
    input  logic               start,
    output logic               busy,
    output logic               sqg_clr,
    input  logic               sqg_wen,
    input  logic [7:0]         sqg_y,
    output logic [LEVEL_W-1:0] level,
    output logic               rd_bank,
    output logic               wr_bank,
    output logic               res_valid,
    input  logic               res_ready,
    output logic [LEVEL_W-1:0] res_level,
    output logic [CNT_W-1:0]   res_count,
    output logic               done
);

    localparam logic [LEVEL_W-1:0] TOP_LEVEL = LEVEL_W'(MAX_IDX);
    localparam logic [LEVEL_W-1:0] LAST_LEVEL = LEVEL_W'(1);

    state_t             state_reg;
    state_t             state_next;
    logic [LEVEL_W-1:0] level_reg;
    logic               rd_bank_reg;
    logic               busy_reg;
    logic               busy_next;
    logic               res_valid_reg;
    logic               res_valid_next;
    logic [LEVEL_W-1:0] res_level_reg;
    logic               done_reg;
    logic               done_next;
    logic               run_last;
    logic               handshake;
    logic [CNT_W-1:0]   box_count;

    assign handshake = res_valid_reg && res_ready;

    bc_box_counter #(
        .MAX_IDX (MAX_IDX),
        .CNT_W   (CNT_W)
    ) u_box_counter (
        .CLK   (CLK),
        .RST_N (RST_N),
        .clr   (state_reg == ST_CLR),
        .run   (state_reg == ST_RUN),
        .level (level_reg),
        .wen   (sqg_wen),
        .y     (sqg_y),
        .count (box_count),
        .last  (run_last)
    );

    // State register.
    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            state_reg <= ST_IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // Next-state decode; a start outside IDLE is simply dropped.
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            ST_IDLE:   if (start) state_next = ST_CLR;
            ST_CLR:    state_next = ST_RUN;
            ST_RUN:    if (run_last) state_next = ST_REPORT;
            ST_REPORT: begin
                if (handshake) begin
                    state_next = (level_reg == LAST_LEVEL) ? ST_DONE : ST_CLR;
                end
            end
            ST_DONE:   state_next = ST_IDLE;
            default:   state_next = ST_IDLE;
        endcase
    end

    // Output decode: generator clear follows the current state, the rest
    // is computed from the next state and registered below.
    always_comb begin
        sqg_clr        = (state_reg != ST_RUN);
        busy_next      = (state_next != ST_IDLE);
        res_valid_next = (state_next == ST_REPORT);
        done_next      = (state_next == ST_DONE);
    end

    // Registered outputs, level and bank selection.
    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            busy_reg      <= 1'b0;
            res_valid_reg <= 1'b0;
            done_reg      <= 1'b0;
            res_level_reg <= '0;
            level_reg     <= TOP_LEVEL;
            rd_bank_reg   <= 1'b0;
        end else begin
            busy_reg      <= busy_next;
            res_valid_reg <= res_valid_next;
            done_reg      <= done_next;
            if ((state_reg == ST_RUN) && run_last) begin
                res_level_reg <= level_reg;
            end
            if ((state_reg == ST_IDLE) && start) begin
                level_reg   <= TOP_LEVEL;
                rd_bank_reg <= 1'b0;
            end else if ((state_reg == ST_REPORT) && handshake && (level_reg != LAST_LEVEL)) begin
                level_reg   <= level_reg - LEVEL_W'(1);
                rd_bank_reg <= ~rd_bank_reg;
            end
        end
    end

    // The box counter only moves during RUN, so it already holds the
    // result stable for the whole REPORT phase.
    assign busy      = busy_reg;
    assign res_valid = res_valid_reg;
    assign done      = done_reg;
    assign res_level = res_level_reg;
    assign res_count = box_count;
    assign level     = level_reg;
    assign rd_bank   = rd_bank_reg;
    assign wr_bank   = ~rd_bank_reg;

endmodule
